// File: rtl/time_tick_ctrl.sv
// time_tick_ctrl: run/pause/clear controller and prescaler feeding the 8-bit
// time counter. Buttons are synchronized and edge-detected into one-cycle
// events. While running, one Inc pulse is issued every DIV cycles until the
// fed-back counter value reaches LIMIT.
// Optional feature macro: TTC_AUTO_CLEAR_EN (go in DONE clears and restarts).
module time_tick_ctrl #(
    parameter int unsigned DIV   = 100000000,
    parameter int unsigned PW    = 27,
    parameter logic [7:0]  LIMIT = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_go,
    input  logic       btn_stop,
    input  logic       btn_clr,
    input  logic [7:0] time_q,
    output logic       Inc,
    output logic       R,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [PW-1:0] PCNT_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PCNT_ONE  = PW'(32'd1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 32'd1);

    // Bit order in the button vectors: [2]=clr, [1]=stop, [0]=go
    logic [2:0]    btn_s;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    sync3_q;
    logic [2:0]    evt_q;
    logic          go_evt_s;
    logic          stop_evt_s;
    logic          clr_evt_s;
    logic          tick_s;
    logic          at_limit_s;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          inc_q;
    logic          inc_d;
    logic          r_q;
    logic          r_d;
    logic          running_q;
    logic          done_q;

    assign btn_s      = {btn_clr, btn_stop, btn_go};
    assign go_evt_s   = evt_q[0];
    assign stop_evt_s = evt_q[1];
    assign clr_evt_s  = evt_q[2];
    assign tick_s     = (pcnt_q == PCNT_LAST);
    // While R is out the counter still shows its old value for one edge,
    // so the limit is not trusted in that cycle (matters for auto-clear).
    assign at_limit_s = (time_q == LIMIT) && !r_q;

    // Two-flop synchronizers, edge-history flop and registered rising-edge events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            sync3_q <= 3'b000;
            evt_q   <= 3'b000;
        end else begin
            sync1_q <= btn_s;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            evt_q   <= sync2_q & ~sync3_q;
        end
    end

    // Next-state, prescaler and pulse decode; clear overrides everything
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        inc_d   = 1'b0;
        r_d     = 1'b0;
        if (clr_evt_s) begin
            state_d = ST_IDLE;
            pcnt_d  = PCNT_ZERO;
            r_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pcnt_d = PCNT_ZERO;
                    if (go_evt_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop_evt_s) begin
                        // Pause freezes the prescaler and swallows a coincident tick
                        state_d = ST_PAUSE;
                        pcnt_d  = pcnt_q;
                    end else if (at_limit_s) begin
                        state_d = ST_DONE;
                        pcnt_d  = PCNT_ZERO;
                    end else if (tick_s) begin
                        pcnt_d = PCNT_ZERO;
                        inc_d  = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_ONE;
                    end
                end
                ST_PAUSE: begin
                    if (go_evt_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    pcnt_d = PCNT_ZERO;
`ifdef TTC_AUTO_CLEAR_EN
                    if (go_evt_s) begin
                        state_d = ST_RUN;
                        r_d     = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    state_d = ST_DONE;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    pcnt_d  = PCNT_ZERO;
                end
            endcase
        end
    end

    // State, prescaler and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pcnt_q    <= PCNT_ZERO;
            inc_q     <= 1'b0;
            r_q       <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            inc_q     <= inc_d;
            r_q       <= r_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign Inc     = inc_q;
    assign R       = r_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_time_tick_ctrl.sv
// Directed bench for time_tick_ctrl with DIV=4, LIMIT=3 and a model of the
// downstream 8-bit counter (increments on Inc, clears on R).
module tb_time_tick_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_go = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_clr = 1'b0;
    logic [7:0] time_q;
    logic       Inc;
    logic       R;
    logic       running;
    logic       done;

    int checks = 0;
    int errors = 0;
    int inc_cnt = 0;
    int r_cnt = 0;
    int inc_base;
    int r_base;

    time_tick_ctrl #(
        .DIV   (4),
        .PW    (3),
        .LIMIT (8'h03)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_go   (btn_go),
        .btn_stop (btn_stop),
        .btn_clr  (btn_clr),
        .time_q   (time_q),
        .Inc      (Inc),
        .R        (R),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Downstream counter model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) time_q <= 8'h00;
        else if (R) time_q <= 8'h00;
        else if (Inc) time_q <= time_q + 8'h01;
    end

    // Pulse counters
    always @(posedge clk) begin
        if (Inc) inc_cnt <= inc_cnt + 1;
        if (R) r_cnt <= r_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        cyc(3);
        check_eq("rst_inc", Inc, 1'b0);
        check_eq("rst_r", R, 1'b0);
        check_eq("rst_running", running, 1'b0);
        check_eq("rst_done", done, 1'b0);
        rst_n = 1'b1;
        cyc(2);

        // Go: run to LIMIT with Inc every 4 cycles
        btn_go = 1'b1;
        cyc(3);
        check_eq("go_latency_early", running, 1'b0);
        cyc(1);
        check_eq("go_running", running, 1'b1);
        btn_go = 1'b0;
        inc_base = inc_cnt;
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            check_eq($sformatf("go_inc_%0d", i), Inc, ((i % 4 == 0) && (i <= 12)) ? 32'd1 : 32'd0);
            check_eq($sformatf("go_tq_%0d", i), time_q, (i >= 13) ? 32'd3 : 32'((i - 1) / 4));
            check_eq($sformatf("go_done_%0d", i), done, (i >= 14) ? 32'd1 : 32'd0);
            check_eq($sformatf("go_run_%0d", i), running, (i >= 14) ? 32'd0 : 32'd1);
        end
        cyc(4);
        check_eq("go_inc_total", inc_cnt - inc_base, 32'd3);

        // DONE + go
        btn_go = 1'b1;
        cyc(1);
        btn_go = 1'b0;
        cyc(3);
`ifdef TTC_AUTO_CLEAR_EN
        check_eq("ac_r", R, 1'b1);
        check_eq("ac_inc", Inc, 1'b0);
        check_eq("ac_running", running, 1'b1);
        cyc(1);
        check_eq("ac_tq", time_q, 8'h00);
        check_eq("ac_r_off", R, 1'b0);
        cyc(3);
        check_eq("ac_first_inc", Inc, 1'b1);
        cyc(12);
        check_eq("ac_done_again", done, 1'b1);
`else
        check_eq("dg_r", R, 1'b0);
        check_eq("dg_done", done, 1'b1);
        cyc(10);
        check_eq("dg_done_hold", done, 1'b1);
        check_eq("dg_tq", time_q, 8'h03);
`endif

        // Clear out of DONE
        btn_clr = 1'b1;
        cyc(1);
        btn_clr = 1'b0;
        cyc(3);
        check_eq("clr_r", R, 1'b1);
        check_eq("clr_done", done, 1'b0);
        cyc(1);
        check_eq("clr_r_off", R, 1'b0);
        check_eq("clr_tq", time_q, 8'h00);

        // Pause at pcnt=2, then resume
        btn_go = 1'b1;
        cyc(3);
        btn_go = 1'b0;
        btn_stop = 1'b1;
        cyc(1);
        check_eq("pz_running", running, 1'b1);
        cyc(1);
        btn_stop = 1'b0;
        cyc(2);
        check_eq("pz_paused", running, 1'b0);
        check_eq("pz_not_done", done, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check_eq($sformatf("pz_no_inc_%0d", i), Inc, 1'b0);
        end
        btn_go = 1'b1;
        cyc(1);
        btn_go = 1'b0;
        cyc(3);
        check_eq("rs_running", running, 1'b1);
        cyc(1);
        check_eq("rs_inc_early", Inc, 1'b0);
        cyc(1);
        check_eq("rs_inc", Inc, 1'b1);
        btn_clr = 1'b1;
        cyc(1);
        check_eq("rs_inc_width", Inc, 1'b0);
        check_eq("rs_tq", time_q, 8'h01);
        btn_clr = 1'b0;

        // Clear coinciding with a tick
        cyc(3);
        check_eq("cc_r", R, 1'b1);
        check_eq("cc_inc", Inc, 1'b0);
        check_eq("cc_running", running, 1'b0);
        cyc(1);
        check_eq("cc_tq", time_q, 8'h00);

        // Held clear: one R pulse only
        r_base = r_cnt;
        btn_clr = 1'b1;
        cyc(50);
        btn_clr = 1'b0;
        cyc(5);
        check_eq("hold_clr_one", r_cnt - r_base, 32'd1);

        // Held go: one run to DONE, nothing afterwards
        inc_base = inc_cnt;
        btn_go = 1'b1;
        cyc(50);
        btn_go = 1'b0;
        check_eq("hold_go_done", done, 1'b1);
        check_eq("hold_go_incs", inc_cnt - inc_base, 32'd3);
        check_eq("hold_go_tq", time_q, 8'h03);
        btn_clr = 1'b1;
        cyc(1);
        btn_clr = 1'b0;
        cyc(6);

        // Stop and go together in RUN: stop wins
        btn_go = 1'b1;
        cyc(1);
        btn_go = 1'b0;
        cyc(3);
        check_eq("pri_running", running, 1'b1);
        btn_go = 1'b1;
        btn_stop = 1'b1;
        cyc(4);
        check_eq("pri_paused", running, 1'b0);
        check_eq("pri_not_done", done, 1'b0);
        check_eq("pri_no_inc", Inc, 1'b0);
        btn_go = 1'b0;
        btn_stop = 1'b0;
        cyc(4);

        // Async reset mid-RUN
        btn_go = 1'b1;
        cyc(1);
        btn_go = 1'b0;
        cyc(3);
        check_eq("ar_running", running, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_running_off", running, 1'b0);
        check_eq("ar_inc_off", Inc, 1'b0);
        check_eq("ar_r_off", R, 1'b0);
        check_eq("ar_done_off", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        inc_base = inc_cnt;
        cyc(20);
        check_eq("ar_no_inc", inc_cnt - inc_base, 32'd0);
        check_eq("ar_idle", running, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
